// File: rtl/vector_gather_pkg.sv
// Shared sizing for the column fetcher / vector gather pair, plus the
// end-of-row sentinel used when VECTOR_GATHER_EOR_EN is defined.
package vector_gather_pkg;

    localparam int CHANNEL_NUM     = 8;
    localparam int CHANNEL_NUM_LOG = 3;
    localparam int COL_ID_SIZE     = 16;
    localparam int VAL_SIZE        = 16;
    localparam int ADDR_SIZE       = 13;

    localparam logic [COL_ID_SIZE-1:0] EOR_SENTINEL = {COL_ID_SIZE{1'b1}};

    typedef logic [CHANNEL_NUM_LOG-1:0] chan_t;

    typedef struct packed {
        logic  valid;
        chan_t ch;
    } s1_t;

    typedef struct packed {
        logic  valid;
        chan_t ch;
        logic  last;
    } s2_t;

    // Channel index after ch, wrapping the last channel back to zero.
    function automatic chan_t next_chan(input chan_t ch);
        chan_t nxt;
        if (ch == chan_t'(CHANNEL_NUM - 1)) begin
            nxt = {CHANNEL_NUM_LOG{1'b0}};
        end else begin
            nxt = ch + {{(CHANNEL_NUM_LOG-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vector_gather_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr,
// wrapping; purely combinational.
module rr_arbiter
    import vector_gather_pkg::*;
(
    input  logic [CHANNEL_NUM-1:0]     req,
    input  logic [CHANNEL_NUM_LOG-1:0] rr_ptr,
    output logic [CHANNEL_NUM-1:0]     grant,
    output logic [CHANNEL_NUM_LOG-1:0] grant_idx,
    output logic                       grant_valid
);

    // Walk the channels starting at rr_ptr; the first hit wins and masks the rest.
    always_comb begin
        logic [CHANNEL_NUM_LOG-1:0] idx_s;
        logic                       hit_s;
        grant       = {CHANNEL_NUM{1'b0}};
        grant_idx   = {CHANNEL_NUM_LOG{1'b0}};
        grant_valid = 1'b0;
        idx_s       = rr_ptr;
        hit_s       = 1'b0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            hit_s        = req[idx_s] & ~grant_valid;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            grant_valid  = grant_valid | hit_s;
            idx_s        = next_chan(idx_s);
        end
    end

endmodule

// File: rtl/vector_gather.sv
// Drains per-channel column-id FIFOs round-robin, looks each id up in the
// vector RAM and parks the operand in a per-channel valid/ready slot.
// Define VECTOR_GATHER_EOR_EN to treat an all-ones id as end-of-row.
module vector_gather
    import vector_gather_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNEL_NUM-1:0]          fifo_empty,
    input  logic [COL_ID_SIZE*CHANNEL_NUM-1:0] fifo_data,
    output logic [CHANNEL_NUM-1:0]          fifo_read,
    output logic [ADDR_SIZE-1:0]            vec_addr,
    input  logic [VAL_SIZE-1:0]             vec_data,
    output logic [CHANNEL_NUM-1:0]          out_valid,
    input  logic [CHANNEL_NUM-1:0]          out_ready,
    output logic [VAL_SIZE*CHANNEL_NUM-1:0] out_data,
    output logic [CHANNEL_NUM-1:0]          out_last
);

`ifdef VECTOR_GATHER_EOR_EN
    localparam logic EOR_EN = 1'b1;
`else
    localparam logic EOR_EN = 1'b0;
`endif

    s1_t                             s1_r;
    s2_t                             s2_r;
    chan_t                           rr_ptr_r;
    logic [ADDR_SIZE-1:0]            addr_hold_r;
    logic [CHANNEL_NUM-1:0]          out_valid_r;
    logic [CHANNEL_NUM-1:0]          out_last_r;
    logic [VAL_SIZE*CHANNEL_NUM-1:0] out_data_r;

    logic [CHANNEL_NUM-1:0]          in_flight_s;
    logic [CHANNEL_NUM-1:0]          req_s;
    logic [CHANNEL_NUM-1:0]          grant_s;
    chan_t                           grant_idx_s;
    logic                            grant_valid_s;
    logic [COL_ID_SIZE-1:0]          s1_col_s;
    logic                            s1_last_s;

    // A channel already in stage 1, stage 2 or holding a full slot may not pop again.
    always_comb begin
        in_flight_s           = out_valid_r;
        in_flight_s[s1_r.ch]  = in_flight_s[s1_r.ch] | s1_r.valid;
        in_flight_s[s2_r.ch]  = in_flight_s[s2_r.ch] | s2_r.valid;
        req_s                 = ~fifo_empty & ~in_flight_s;
    end

    rr_arbiter u_arb (
        .req         (req_s),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // The pop must go out in the grant cycle, so fifo_read is combinational.
    assign fifo_read = rst ? {CHANNEL_NUM{1'b0}} : grant_s;

    assign s1_col_s  = fifo_data[s1_r.ch*COL_ID_SIZE +: COL_ID_SIZE];
    assign s1_last_s = EOR_EN & (s1_col_s == EOR_SENTINEL);
    assign vec_addr  = s1_r.valid ? s1_col_s[ADDR_SIZE-1:0] : addr_hold_r;

    // Pipeline stages, held RAM address and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r.valid  <= 1'b0;
            s1_r.ch     <= {CHANNEL_NUM_LOG{1'b0}};
            s2_r.valid  <= 1'b0;
            s2_r.ch     <= {CHANNEL_NUM_LOG{1'b0}};
            s2_r.last   <= 1'b0;
            addr_hold_r <= {ADDR_SIZE{1'b0}};
            rr_ptr_r    <= {CHANNEL_NUM_LOG{1'b0}};
        end else begin
            s1_r.valid <= grant_valid_s;
            s1_r.ch    <= grant_idx_s;
            s2_r.valid <= s1_r.valid;
            s2_r.ch    <= s1_r.ch;
            s2_r.last  <= s1_last_s;
            if (s1_r.valid) begin
                addr_hold_r <= s1_col_s[ADDR_SIZE-1:0];
            end else begin
                addr_hold_r <= addr_hold_r;
            end
            if (grant_valid_s) begin
                rr_ptr_r <= next_chan(grant_idx_s);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Output slots: load from stage 2, empty on handshake; never both on one channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= {CHANNEL_NUM{1'b0}};
            out_last_r  <= {CHANNEL_NUM{1'b0}};
            out_data_r  <= {(VAL_SIZE*CHANNEL_NUM){1'b0}};
        end else begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (s2_r.valid && (s2_r.ch == chan_t'(i))) begin
                    out_valid_r[i] <= 1'b1;
                    out_last_r[i]  <= s2_r.last;
                    out_data_r[i*VAL_SIZE +: VAL_SIZE] <= s2_r.last ? {VAL_SIZE{1'b0}} : vec_data;
                end else if (out_valid_r[i] && out_ready[i]) begin
                    out_valid_r[i] <= 1'b0;
                end else begin
                    out_valid_r[i] <= out_valid_r[i];
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_vector_gather.sv
// Directed and random checks of vector_gather against a queue-based model
// of the FIFOs, vector RAM and per-channel operand slots.
module tb_vector_gather;
    import vector_gather_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [CHANNEL_NUM-1:0]          fifo_empty;
    logic [COL_ID_SIZE*CHANNEL_NUM-1:0] fifo_data;
    logic [CHANNEL_NUM-1:0]          fifo_read;
    logic [ADDR_SIZE-1:0]            vec_addr;
    logic [VAL_SIZE-1:0]             vec_data;
    logic [CHANNEL_NUM-1:0]          out_valid;
    logic [CHANNEL_NUM-1:0]          out_ready;
    logic [VAL_SIZE*CHANNEL_NUM-1:0] out_data;
    logic [CHANNEL_NUM-1:0]          out_last;

    vector_gather dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read), .vec_addr(vec_addr), .vec_data(vec_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:8191];
    logic [15:0] q [CHANNEL_NUM][$];
    bit          busy [CHANNEL_NUM];
    int          pop_cyc [CHANNEL_NUM];
    int          pop_cnt [CHANNEL_NUM];
    logic [15:0] exp_data [CHANNEL_NUM];
    logic        exp_last [CHANNEL_NUM];
    logic [15:0] xfer_data [CHANNEL_NUM];
    logic        xfer_last [CHANNEL_NUM];
    int          xfer_cyc [CHANNEL_NUM];
    int          grant_log [$];
    int          mptr, cyc, t0, base, n_push, n_pop;
    logic [12:0] last_addr;
    bit          prev_pop_valid;
    logic [15:0] prev_pop_id;
    bit          eor_en;
    int          n_assert, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int ch, input logic [15:0] id);
        q[ch].push_back(id);
        fifo_empty[ch] = 1'b0;
        n_push++;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance model and environment.
    task automatic step();
        int                     g;
        logic [CHANNEL_NUM-1:0] exp_rd, exp_v, xfer;
        logic [12:0]            exp_addr, seen_addr;
        logic [15:0]            id;
        #4;
        g = -1;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            int idx;
            idx = (mptr + k) % CHANNEL_NUM;
            if (g < 0 && q[idx].size() > 0 && !busy[idx]) g = idx;
        end
        exp_rd = (g >= 0) ? (8'b1 << g) : 8'b0;
        chk("fifo_read", fifo_read, exp_rd);
        chk("fifo_read_onehot0", $onehot0(fifo_read), 1);
        exp_addr = prev_pop_valid ? prev_pop_id[12:0] : last_addr;
        chk("vec_addr", vec_addr, exp_addr);
        seen_addr = vec_addr;
        for (int i = 0; i < CHANNEL_NUM; i++) exp_v[i] = busy[i] && (cyc >= pop_cyc[i] + 3);
        chk("out_valid", out_valid, exp_v);
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (exp_v[i]) begin
                chk($sformatf("out_data[%0d]", i), out_data[i*16 +: 16], exp_data[i]);
                chk($sformatf("out_last[%0d]", i), out_last[i], exp_last[i]);
            end
        end
        xfer = exp_v & out_ready;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (xfer[i]) begin
                xfer_data[i] = out_data[i*16 +: 16];
                xfer_last[i] = out_last[i];
                xfer_cyc[i]  = cyc;
            end
        end
        @(posedge clk);
        #1;
        last_addr = exp_addr;
        vec_data  = ram[seen_addr];
        prev_pop_valid = (g >= 0);
        if (g >= 0) begin
            id = q[g].pop_front();
            prev_pop_id = id;
            fifo_data[g*16 +: 16] = id;
            busy[g]     = 1'b1;
            pop_cyc[g]  = cyc;
            pop_cnt[g]++;
            n_pop++;
            exp_last[g] = eor_en && (id == 16'hFFFF);
            exp_data[g] = exp_last[g] ? 16'h0000 : ram[id[12:0]];
            mptr = (g + 1) % CHANNEL_NUM;
        end
        grant_log.push_back(g);
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (xfer[i]) busy[i] = 1'b0;
            fifo_empty[i] = (q[i].size() == 0);
        end
        cyc++;
    endtask

    // Assert reset mid-cycle, check outputs drop at once, and clear the model (FIFOs share rst).
    task automatic reset_mid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_vec_addr", vec_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data_zero", (out_data == 128'd0), 1);
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            n_push -= q[i].size();
            q[i].delete();
            busy[i] = 1'b0;
        end
        mptr = 0; last_addr = 13'd0; prev_pop_valid = 1'b0;
        fifo_empty = 8'hFF;
        fifo_data  = 128'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
`ifdef VECTOR_GATHER_EOR_EN
        eor_en = 1'b1;
`else
        eor_en = 1'b0;
`endif
        n_assert = 0; n_fail = 0; cyc = 0; mptr = 0; n_push = 0; n_pop = 0;
        last_addr = 13'd0; prev_pop_valid = 1'b0; prev_pop_id = 16'h0000;
        for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            busy[i] = 1'b0; pop_cnt[i] = 0; pop_cyc[i] = 0; xfer_cyc[i] = -1;
        end
        rst = 1'b1; fifo_empty = 8'hFF; fifo_data = 128'd0; vec_data = 16'h0000; out_ready = 8'h00;
        #3;
        chk("init_fifo_read", fifo_read, 0);
        chk("init_vec_addr", vec_addr, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_out_last", out_last, 0);
        chk("init_out_data_zero", (out_data == 128'd0), 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single channel: id 5 -> 0xABCD, three-cycle latency, one pop.
        ram[5] = 16'hABCD;
        out_ready = 8'hFF;
        t0 = cyc;
        push(0, 16'd5);
        repeat (6) step();
        chk("single_grant", grant_log[t0], 0);
        chk("single_xfer_cyc", xfer_cyc[0], t0 + 3);
        chk("single_xfer_data", xfer_data[0], 16'hABCD);
        chk("single_pops", pop_cnt[0], 1);

        // All channels busy: grants 0..7 then 0 again.
        reset_mid();
        t0 = cyc;
        for (int i = 0; i < CHANNEL_NUM; i++)
            for (int j = 0; j < 3; j++) push(i, 16'($urandom));
        repeat (32) step();
        for (int k = 0; k <= 8; k++) chk($sformatf("order_grant%0d", k), grant_log[t0 + k], k % 8);

        // Backpressure on channel 2.
        out_ready = 8'hFB;
        t0 = cyc;
        base = pop_cnt[2];
        for (int j = 0; j < 3; j++) push(2, 16'($urandom));
        repeat (20) step();
        chk("bp_single_pop", pop_cnt[2] - base, 1);
        out_ready = 8'hFF;
        repeat (2) step();
        chk("bp_xfer_cyc", xfer_cyc[2], t0 + 20);
        chk("bp_next_pop", grant_log[t0 + 21], 2);
        repeat (12) step();

        // Wrap: pointer parked at 7, requests on 7 and 0.
        reset_mid();
        t0 = cyc;
        push(6, 16'd100);
        step();
        push(7, 16'd200);
        push(0, 16'd300);
        repeat (2) step();
        chk("wrap_grant6", grant_log[t0], 6);
        chk("wrap_grant7", grant_log[t0 + 1], 7);
        chk("wrap_grant0", grant_log[t0 + 2], 0);
        repeat (8) step();

        // All-ones column id.
        ram[13'h1FFF] = 16'h1234;
        push(3, 16'hFFFF);
        repeat (6) step();
        chk("eor_data", xfer_data[3], eor_en ? 16'h0000 : 16'h1234);
        chk("eor_last", xfer_last[3], eor_en ? 1 : 0);

        // Reset with two entries in stages 1 and 2.
        push(1, 16'd11);
        push(4, 16'd44);
        repeat (2) step();
        reset_mid();
        repeat (6) step();
        t0 = cyc;
        push(5, 16'd55);
        repeat (5) step();
        chk("post_rst_xfer", xfer_cyc[5], t0 + 3);

        // Random traffic with random backpressure.
        for (int r = 0; r < 600; r++) begin
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                if ($urandom_range(3) == 0 && q[ch].size() < 4)
                    push(ch, ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom));
            end
            out_ready = 8'($urandom);
            step();
        end
        out_ready = 8'hFF;
        repeat (40) step();
        chk("drain_pops", n_pop, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
